// File: rtl/key_epoch_scheduler.sv
// Key rotation sequencer for the key fob.
// Turns the divider's clk_5s and clk_500Hz levels plus the user rekey level
// into single-cycle events, runs a req/ack handshake with the key generator
// (with an ack timeout), installs each returned key, and scans the installed
// key nibble by nibble onto the hex display.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; waiting for a pending trigger
// REQ   | gen_req high, waiting for gen_ack or for the ack timeout
// HOLD  | key installed, waiting for the generator to drop gen_ack
module key_epoch_scheduler #(
    parameter int EPOCH_W     = 32,
    parameter int DIGITS      = 4,
    parameter int ACK_TIMEOUT = 1000,
    localparam int KEY_W      = 4 * DIGITS
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               clk_5s,
    input  logic               clk_500Hz,
    input  logic               force_rekey,
    output logic               gen_req,
    output logic [EPOCH_W-1:0] gen_epoch,
    input  logic               gen_ack,
    input  logic [KEY_W-1:0]   gen_key,
    output logic [KEY_W-1:0]   cur_key,
    output logic               key_valid,
    output logic [EPOCH_W-1:0] epoch,
    output logic               timeout_err,
    output logic [DIGITS-1:0]  digit_sel,
    output logic [3:0]         digit_val
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]   IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  SEL_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic               pending_q;
    logic               gen_req_q;
    logic [EPOCH_W-1:0] gen_epoch_q;
    logic [KEY_W-1:0]   cur_key_q;
    logic               key_valid_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               timeout_err_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_d;

    logic               hist_5s_q;
    logic               hist_500_q;
    logic               hist_force_q;
    logic               evt_5s;
    logic               evt_500;
    logic               evt_force;
    logic               trigger;

    logic [IDX_W-1:0]   scan_idx_q;
    logic [IDX_W-1:0]   scan_idx_d;
    logic [DIGITS-1:0]  digit_sel_q;
    logic [3:0]         digit_val_q;
    logic [KEY_W-1:0]   key_shifted;

    // Input history; loading the live inputs during reset as well means no
    // edge is reported on the first cycle after rst falls.
    always_ff @(posedge sys_clk) begin
        hist_5s_q    <= clk_5s;
        hist_500_q   <= clk_500Hz;
        hist_force_q <= force_rekey;
    end

    // Rising-edge events and the combined rekey trigger.
    always_comb begin
        evt_5s    = clk_5s & ~hist_5s_q;
        evt_500   = clk_500Hz & ~hist_500_q;
        evt_force = force_rekey & ~hist_force_q;
        trigger   = evt_5s | evt_force;
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end

    // Handshake FSM with pending-trigger coalescing, timeout and key install.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b1;
            gen_req_q     <= 1'b0;
            gen_epoch_q   <= EPOCH_ONE;
            cur_key_q     <= '0;
            key_valid_q   <= 1'b0;
            epoch_q       <= '0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            // Triggers arriving while busy collapse into one pending flag;
            // IDLE below overrides this when it consumes the trigger directly.
            if (trigger) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pending_q || trigger) begin
                        pending_q   <= 1'b0;
                        state_q     <= REQ;
                        gen_req_q   <= 1'b1;
                        gen_epoch_q <= epoch_q + EPOCH_ONE;
                        tmo_cnt_q   <= '0;
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack landing on the final
                    // timeout cycle still installs the key without an error.
                    if (gen_ack) begin
                        cur_key_q   <= gen_key;
                        key_valid_q <= 1'b1;
                        epoch_q     <= epoch_q + EPOCH_ONE;
                        gen_req_q   <= 1'b0;
                        state_q     <= HOLD;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                        if (tmo_cnt_d == TMO_LIMIT) begin
                            gen_req_q     <= 1'b0;
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!gen_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gen_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Next scan position: advance on each 500 Hz edge, wrapping after the
    // last digit. The key nibble is picked from the next index so the
    // displayed digit follows the scan edge without an extra cycle of lag.
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (evt_500) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_ONE;
        end
        key_shifted = cur_key_q >> {scan_idx_d, 2'b00};
    end

    // Display scan registers; blanked until the first key is installed.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            scan_idx_q  <= '0;
            digit_sel_q <= '0;
            digit_val_q <= '0;
        end else begin
            scan_idx_q <= scan_idx_d;
            if (key_valid_q) begin
                digit_sel_q <= SEL_ONE << scan_idx_d;
                digit_val_q <= key_shifted[3:0];
            end else begin
                digit_sel_q <= '0;
                digit_val_q <= '0;
            end
        end
    end

    assign gen_req     = gen_req_q;
    assign gen_epoch   = gen_epoch_q;
    assign cur_key     = cur_key_q;
    assign key_valid   = key_valid_q;
    assign epoch       = epoch_q;
    assign timeout_err = timeout_err_q;
    assign digit_sel   = digit_sel_q;
    assign digit_val   = digit_val_q;

endmodule

// File: tb/tb_key_epoch_scheduler.sv
// Directed bench for key_epoch_scheduler (EPOCH_W=4, DIGITS=4, ACK_TIMEOUT=8).
module tb_key_epoch_scheduler;

    localparam int EPOCH_W = 4;
    localparam int DIGITS  = 4;
    localparam int KEY_W   = 16;

    logic               sys_clk;
    logic               rst;
    logic               clk_5s;
    logic               clk_500Hz;
    logic               force_rekey;
    logic               gen_req;
    logic [EPOCH_W-1:0] gen_epoch;
    logic               gen_ack;
    logic [KEY_W-1:0]   gen_key;
    logic [KEY_W-1:0]   cur_key;
    logic               key_valid;
    logic [EPOCH_W-1:0] epoch;
    logic               timeout_err;
    logic [DIGITS-1:0]  digit_sel;
    logic [3:0]         digit_val;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] val;
    } disp_vec_t;

    typedef struct {
        logic        use_5s;
        int          delay;
        logic [15:0] key;
        logic [3:0]  exp_gen_epoch;
        logic [3:0]  exp_epoch;
    } rekey_vec_t;

    disp_vec_t  dv[5];
    rekey_vec_t rk[10];

    key_epoch_scheduler #(
        .EPOCH_W     (EPOCH_W),
        .DIGITS      (DIGITS),
        .ACK_TIMEOUT (8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .clk_5s      (clk_5s),
        .clk_500Hz   (clk_500Hz),
        .force_rekey (force_rekey),
        .gen_req     (gen_req),
        .gen_epoch   (gen_epoch),
        .gen_ack     (gen_ack),
        .gen_key     (gen_key),
        .cur_key     (cur_key),
        .key_valid   (key_valid),
        .epoch       (epoch),
        .timeout_err (timeout_err),
        .digit_sel   (digit_sel),
        .digit_val   (digit_val)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_gen_req"},     32'(gen_req),     32'h0);
        chk({tag, "_gen_epoch"},   32'(gen_epoch),   32'h1);
        chk({tag, "_cur_key"},     32'(cur_key),     32'h0);
        chk({tag, "_key_valid"},   32'(key_valid),   32'h0);
        chk({tag, "_epoch"},       32'(epoch),       32'h0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
        chk({tag, "_digit_sel"},   32'(digit_sel),   32'h0);
        chk({tag, "_digit_val"},   32'(digit_val),   32'h0);
    endtask

    // Waits 'delay' cycles in REQ, acks once, then releases ack (HOLD -> IDLE).
    task automatic install(input logic [15:0] key, input int delay, input logic [3:0] exp_ep);
        repeat (delay) tick();
        gen_ack = 1'b1;
        gen_key = key;
        tick();
        chk("ack_drops_req", 32'(gen_req),   32'h0);
        chk("cur_key",       32'(cur_key),   32'(key));
        chk("epoch",         32'(epoch),     32'(exp_ep));
        chk("key_valid",     32'(key_valid), 32'h1);
        gen_ack = 1'b0;
        gen_key = '0;
        tick();
    endtask

    initial begin
        int n;
        int extra;

        // Display sequence for key 0xBEEF: nibbles F,E,E,B from digit 0 up.
        dv[0] = '{sel: 4'b0001, val: 4'hF};
        dv[1] = '{sel: 4'b0010, val: 4'hE};
        dv[2] = '{sel: 4'b0100, val: 4'hE};
        dv[3] = '{sel: 4'b1000, val: 4'hB};
        dv[4] = '{sel: 4'b0001, val: 4'hF};

        // Rekeys starting from epoch 6: requests 7..15 then wrap to 0.
        for (int i = 0; i < 10; i++) begin
            rk[i].use_5s        = (i % 2) == 1;
            rk[i].delay         = i % 5;
            rk[i].key           = 16'hA000 + 16'(i) * 16'h0111;
            rk[i].exp_gen_epoch = 4'(7 + i);
            rk[i].exp_epoch     = 4'(7 + i);
        end

        rst         = 1'b1;
        clk_5s      = 1'b0;
        clk_500Hz   = 1'b0;
        force_rekey = 1'b0;
        gen_ack     = 1'b0;
        gen_key     = '0;

        // Startup request
        repeat (3) tick();
        chk_reset_values("rst");
        rst = 1'b0;
        tick();
        chk("start_gen_req",   32'(gen_req),   32'h1);
        chk("start_gen_epoch", 32'(gen_epoch), 32'h1);
        install(16'hBEEF, 4, 4'd1);

        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                clk_500Hz = 1'b1;
                tick();
            end
            chk("scan_sel", 32'(digit_sel), 32'(dv[i].sel));
            chk("scan_val", 32'(digit_val), 32'(dv[i].val));
            clk_500Hz = 1'b0;
            tick();
        end

        // Periodic rotation with immediate ack
        clk_5s = 1'b1;
        tick();
        chk("periodic_req",   32'(gen_req),   32'h1);
        chk("periodic_epoch", 32'(gen_epoch), 32'h2);
        clk_5s = 1'b0;
        install(16'h1234, 0, 4'd2);

        // Ack on the final timeout cycle wins
        clk_5s = 1'b1;
        tick();
        chk("collide_gen_epoch", 32'(gen_epoch), 32'h3);
        clk_5s = 1'b0;
        install(16'hCAFE, 7, 4'd3);
        chk("collide_no_err", 32'(timeout_err), 32'h0);

        // Timeout with ack held low
        clk_5s = 1'b1;
        tick();
        chk("tmo_req",       32'(gen_req),   32'h1);
        chk("tmo_gen_epoch", 32'(gen_epoch), 32'h4);
        clk_5s = 1'b0;
        n = 0;
        while (gen_req && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_req_high_cycles", 32'(n),           32'd8);
        chk("tmo_err",             32'(timeout_err), 32'h1);
        chk("tmo_epoch_kept",      32'(epoch),       32'h3);
        chk("tmo_key_kept",        32'(cur_key),     32'hCAFE);
        clk_5s = 1'b1;
        tick();
        chk("retry_req",       32'(gen_req),   32'h1);
        chk("retry_gen_epoch", 32'(gen_epoch), 32'h4);
        clk_5s = 1'b0;
        install(16'h5678, 2, 4'd4);
        chk("tmo_err_sticky", 32'(timeout_err), 32'h1);

        // Coalescing of triggers while busy
        force_rekey = 1'b1;
        tick();
        chk("coal_gen_epoch1", 32'(gen_epoch), 32'h5);
        force_rekey = 1'b0;
        tick();
        force_rekey = 1'b1;
        tick();
        force_rekey = 1'b0;
        clk_5s      = 1'b1;
        tick();
        clk_5s      = 1'b0;
        force_rekey = 1'b1;
        tick();
        force_rekey = 1'b0;
        gen_ack     = 1'b1;
        gen_key     = 16'h1111;
        tick();
        chk("coal_ack_req",   32'(gen_req), 32'h0);
        chk("coal_ack_epoch", 32'(epoch),   32'h5);
        force_rekey = 1'b1;
        tick();
        force_rekey = 1'b0;
        gen_ack     = 1'b0;
        gen_key     = '0;
        tick();
        chk("coal_hold_exit_req", 32'(gen_req), 32'h0);
        tick();
        chk("coal_second_req",   32'(gen_req),   32'h1);
        chk("coal_gen_epoch2",   32'(gen_epoch), 32'h6);
        install(16'h2222, 0, 4'd6);
        extra = 0;
        repeat (10) begin
            tick();
            if (gen_req) extra++;
        end
        chk("coal_no_extra_req", 32'(extra), 32'd0);

        // Rekey table up to and across the epoch wrap
        for (int i = 0; i < 10; i++) begin
            if (rk[i].use_5s) clk_5s = 1'b1;
            else              force_rekey = 1'b1;
            tick();
            chk("tbl_req",       32'(gen_req),   32'h1);
            chk("tbl_gen_epoch", 32'(gen_epoch), 32'(rk[i].exp_gen_epoch));
            clk_5s      = 1'b0;
            force_rekey = 1'b0;
            install(rk[i].key, rk[i].delay, rk[i].exp_epoch);
        end

        // Reset while a request is outstanding
        force_rekey = 1'b1;
        tick();
        chk("midrst_req",       32'(gen_req),   32'h1);
        chk("midrst_gen_epoch", 32'(gen_epoch), 32'h1);
        rst = 1'b1;
        tick();
        chk_reset_values("midrst");
        rst = 1'b0;
        tick();
        chk("post_rst_req",       32'(gen_req),   32'h1);
        chk("post_rst_gen_epoch", 32'(gen_epoch), 32'h1);
        force_rekey = 1'b0;
        install(16'h0F0F, 1, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
